// File: rtl/regfile_mp_if.sv
// Bus bundle between the issue/writeback stages and the multi-ported register file.
// The register file attaches through the slave modport, and its client attaches through the master modport.
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    logic [NUM_WR-1:0]            wen;
    logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]            rbusy;
    logic                         set_en;
    logic [ADDR_WIDTH-1:0]        set_addr;
    logic [ADDR_WIDTH-1:0]        dbg_addr;
    logic [DATA_WIDTH-1:0]        dbg_data;

    modport master (
        output wen, waddr, wdata, raddr, set_en, set_addr, dbg_addr,
        input  rdata, rbusy, dbg_data
    );

    modport slave (
        input  wen, waddr, wdata, raddr, set_en, set_addr, dbg_addr,
        output rdata, rbusy, dbg_data
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with an optional write-to-read bypass,
// a per-register busy scoreboard, and an unbypassed debug read port.
module regfile_mp #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int   DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic ZERO_EN = (ZERO_REG != 32'sd0);
    localparam logic BYP_EN  = (BYPASS != 32'sd0);

    logic [DATA_WIDTH-1:0]     rf_q [DEPTH];
    logic [DATA_WIDTH-1:0]     rf_d [DEPTH];
    logic [DEPTH-1:0]          busy_q;
    logic [DEPTH-1:0]          busy_d;

    logic [ADDR_WIDTH-1:0]     waddr_s    [NUM_WR];
    logic [DATA_WIDTH-1:0]     wdata_s    [NUM_WR];
    logic [NUM_WR-1:0]         wr_valid_s;
    logic [ADDR_WIDTH-1:0]     raddr_s    [NUM_RD];
    logic                      set_valid_s;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_s;
    logic [NUM_RD-1:0]         rbusy_s;

    // Unpack port vectors and qualify writes/sets; nothing takes effect while in reset,
    // and index 0 is filtered out when it is hardwired to zero.
    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            waddr_s[i]    = bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_s[i]    = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wr_valid_s[i] = bus.wen[i] & rst &
                            ~(ZERO_EN & (waddr_s[i] == {ADDR_WIDTH{1'b0}}));
        end
        for (int j = 0; j < NUM_RD; j++) begin
            raddr_s[j] = bus.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
        end
        set_valid_s = bus.set_en & rst &
                      ~(ZERO_EN & (bus.set_addr == {ADDR_WIDTH{1'b0}}));
    end

    // Next-state for registers and busy bits. Ports are scanned low to high, so the highest
    // enabled port wins a collision. The set is applied after the clears because a newly
    // issued producer supersedes the retiring producer.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                rf_d[r]   = (wr_valid_s[i] && (waddr_s[i] == ADDR_WIDTH'(r))) ? wdata_s[i] : rf_d[r];
                busy_d[r] = (wr_valid_s[i] && (waddr_s[i] == ADDR_WIDTH'(r))) ? 1'b0 : busy_d[r];
            end
            busy_d[r] = (set_valid_s && (bus.set_addr == ADDR_WIDTH'(r))) ? 1'b1 : busy_d[r];
        end
    end

    // State registers with asynchronous clear of all contents and busy bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_q[r] <= {DATA_WIDTH{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: array lookup, optionally overridden by a matching same-cycle write.
    // The bypass also drops the busy flag, so the forwarded value can be used at once.
    always_comb begin
        rdata_s = {(NUM_RD*DATA_WIDTH){1'b0}};
        rbusy_s = {NUM_RD{1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            rdata_s[j*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr_s[j]];
            rbusy_s[j]                          = busy_q[raddr_s[j]];
            for (int i = 0; i < NUM_WR; i++) begin
                rdata_s[j*DATA_WIDTH +: DATA_WIDTH] =
                    (BYP_EN && wr_valid_s[i] && (waddr_s[i] == raddr_s[j])) ?
                    wdata_s[i] : rdata_s[j*DATA_WIDTH +: DATA_WIDTH];
                rbusy_s[j] =
                    (BYP_EN && wr_valid_s[i] && (waddr_s[i] == raddr_s[j])) ? 1'b0 : rbusy_s[j];
            end
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.rbusy    = rbusy_s;
    assign bus.dbg_data = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with bypass and one without, driven in lockstep.
module tb_regfile_mp;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    regfile_mp_if bus_a ();
    regfile_mp_if bus_b ();

    regfile_mp #(.BYPASS(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_mp #(.BYPASS(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.wen = 2'b00; bus_a.waddr = 8'h00; bus_a.wdata = 64'h0; bus_a.raddr = 8'h00;
        bus_a.set_en = 1'b0; bus_a.set_addr = 4'h0; bus_a.dbg_addr = 4'h0;
        bus_b.wen = 2'b00; bus_b.waddr = 8'h00; bus_b.wdata = 64'h0; bus_b.raddr = 8'h00;
        bus_b.set_en = 1'b0; bus_b.set_addr = 4'h0; bus_b.dbg_addr = 4'h0;
    endtask

    task automatic drv_wr(input int p, input logic en, input logic [3:0] a, input logic [31:0] d);
        bus_a.wen[p] = en; bus_a.waddr[p*4 +: 4] = a; bus_a.wdata[p*32 +: 32] = d;
        bus_b.wen[p] = en; bus_b.waddr[p*4 +: 4] = a; bus_b.wdata[p*32 +: 32] = d;
    endtask

    task automatic drv_rd(input int p, input logic [3:0] a);
        bus_a.raddr[p*4 +: 4] = a;
        bus_b.raddr[p*4 +: 4] = a;
    endtask

    task automatic drv_set(input logic en, input logic [3:0] a);
        bus_a.set_en = en; bus_a.set_addr = a;
        bus_b.set_en = en; bus_b.set_addr = a;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        drv_wr(0, 1'b1, 4'd4, 32'hCAFE0001);
        drv_set(1'b1, 4'd4);
        step();
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        drv_set(1'b0, 4'd0);
        for (int a = 0; a < 16; a++) begin
            drv_rd(0, 4'(a));
            drv_rd(1, 4'(a));
            #1;
            tests_run++;
            if ({bus_a.rdata, bus_a.rbusy} !== 66'h0) begin
                $display("FAIL reset_read[%0d] got=%h exp=0", a, {bus_a.rdata, bus_a.rbusy});
                tests_failed++;
            end
        end
        step();
        rst = 1'b1;
        drv_wr(0, 1'b1, 4'd5, 32'h00000077);
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        drv_rd(0, 4'd5);
        #1;
        tests_run++;
        if (bus_a.rdata[31:0] !== 32'h00000077) begin
            $display("FAIL pre_async_rst got=%h exp=%h", bus_a.rdata[31:0], 32'h00000077);
            tests_failed++;
        end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus_a.rdata[31:0] !== 32'h0) begin
            $display("FAIL async_rst_x5 got=%h exp=0", bus_a.rdata[31:0]);
            tests_failed++;
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        drive_idle();
        drv_wr(0, 1'b1, 4'd5, 32'hDEADBEEF);
        drv_rd(0, 4'd5);
        #1;
        tests_run++;
        if (bus_a.rdata[31:0] !== 32'hDEADBEEF) begin
            $display("FAIL bypass_same_cycle got=%h exp=%h", bus_a.rdata[31:0], 32'hDEADBEEF);
            tests_failed++;
        end
        tests_run++;
        if (bus_b.rdata[31:0] !== 32'h0) begin
            $display("FAIL nobypass_old_value got=%h exp=0", bus_b.rdata[31:0]);
            tests_failed++;
        end
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus_b.rdata[31:0] !== 32'hDEADBEEF) begin
            $display("FAIL nobypass_next_cycle got=%h exp=%h", bus_b.rdata[31:0], 32'hDEADBEEF);
            tests_failed++;
        end
    endtask

    task automatic test_write_conflict();
        drive_idle();
        drv_wr(0, 1'b1, 4'd7, 32'h11);
        drv_wr(1, 1'b1, 4'd7, 32'h22);
        drv_rd(1, 4'd7);
        #1;
        tests_run++;
        if (bus_a.rdata[63:32] !== 32'h22) begin
            $display("FAIL conflict_bypass got=%h exp=%h", bus_a.rdata[63:32], 32'h22);
            tests_failed++;
        end
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        drv_wr(1, 1'b0, 4'd0, 32'h0);
        drv_rd(0, 4'd7);
        #1;
        tests_run++;
        if (bus_b.rdata[31:0] !== 32'h22) begin
            $display("FAIL conflict_stored got=%h exp=%h", bus_b.rdata[31:0], 32'h22);
            tests_failed++;
        end
        drv_wr(0, 1'b1, 4'd0, 32'h1234);
        drv_rd(0, 4'd0);
        #1;
        tests_run++;
        if (bus_a.rdata[31:0] !== 32'h0) begin
            $display("FAIL x0_bypass got=%h exp=0", bus_a.rdata[31:0]);
            tests_failed++;
        end
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if ({bus_a.rdata[31:0], bus_b.rdata[31:0]} !== 64'h0) begin
            $display("FAIL x0_stored got=%h exp=0", {bus_a.rdata[31:0], bus_b.rdata[31:0]});
            tests_failed++;
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        drv_set(1'b1, 4'd3);
        drv_rd(0, 4'd3);
        step();
        drv_set(1'b0, 4'd0);
        #1;
        tests_run++;
        if (bus_a.rbusy[0] !== 1'b1) begin
            $display("FAIL busy_set got=%b exp=1", bus_a.rbusy[0]);
            tests_failed++;
        end
        drv_wr(1, 1'b1, 4'd3, 32'h55);
        #1;
        tests_run++;
        if ({bus_a.rbusy[0], bus_a.rdata[31:0]} !== {1'b0, 32'h55}) begin
            $display("FAIL busy_bypass_clear got=%b/%h exp=0/%h", bus_a.rbusy[0], bus_a.rdata[31:0], 32'h55);
            tests_failed++;
        end
        tests_run++;
        if (bus_b.rbusy[0] !== 1'b1) begin
            $display("FAIL nobypass_busy_held got=%b exp=1", bus_b.rbusy[0]);
            tests_failed++;
        end
        step();
        drv_wr(1, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if ({bus_a.rbusy[0], bus_b.rbusy[0]} !== 2'b00) begin
            $display("FAIL busy_cleared got=%b exp=00", {bus_a.rbusy[0], bus_b.rbusy[0]});
            tests_failed++;
        end
    endtask

    task automatic test_set_wins();
        drive_idle();
        drv_set(1'b1, 4'd9);
        drv_wr(0, 1'b1, 4'd9, 32'h99);
        drv_rd(1, 4'd9);
        step();
        drv_set(1'b0, 4'd0);
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if ({bus_a.rbusy[1], bus_a.rdata[63:32]} !== {1'b1, 32'h99}) begin
            $display("FAIL set_over_clear got=%b/%h exp=1/%h", bus_a.rbusy[1], bus_a.rdata[63:32], 32'h99);
            tests_failed++;
        end
        drv_set(1'b1, 4'd0);
        drv_rd(0, 4'd0);
        step();
        drv_set(1'b0, 4'd0);
        #1;
        tests_run++;
        if ({bus_a.rbusy[0], bus_b.rbusy[0]} !== 2'b00) begin
            $display("FAIL x0_never_busy got=%b exp=00", {bus_a.rbusy[0], bus_b.rbusy[0]});
            tests_failed++;
        end
    endtask

    task automatic test_debug();
        logic [31:0] exp_v;
        drive_idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        drv_wr(0, 1'b1, 4'd10, 32'hA5A5A5A5);
        drv_wr(1, 1'b1, 4'd15, 32'hFFFFFFFF);
        bus_a.dbg_addr = 4'd10;
        #1;
        tests_run++;
        if (bus_a.dbg_data !== 32'h0) begin
            $display("FAIL dbg_not_bypassed got=%h exp=0", bus_a.dbg_data);
            tests_failed++;
        end
        step();
        drv_wr(0, 1'b0, 4'd0, 32'h0);
        drv_wr(1, 1'b0, 4'd0, 32'h0);
        for (int a = 0; a < 16; a++) begin
            bus_a.dbg_addr = 4'(a);
            bus_b.dbg_addr = 4'(a);
            exp_v = (a == 10) ? 32'hA5A5A5A5 : ((a == 15) ? 32'hFFFFFFFF : 32'h0);
            #1;
            tests_run++;
            if ({bus_a.dbg_data, bus_b.dbg_data} !== {exp_v, exp_v}) begin
                $display("FAIL dbg_sweep[%0d] got=%h/%h exp=%h", a, bus_a.dbg_data, bus_b.dbg_data, exp_v);
                tests_failed++;
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        drive_idle();
        test_reset();
        test_bypass();
        test_write_conflict();
        test_scoreboard();
        test_set_wins();
        test_debug();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
